// File: rtl/instr_seq_pkg.sv
// Shared types and constants for the instr_seq sequencer: opcodes, FSM states,
// instruction field positions and the decode record.
package instr_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'h0,
    OP_LDI       = 4'h1,
    OP_ALU_FIRST = 4'h2,
    OP_ALU_LAST  = 4'hE,
    OP_HALT      = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    K_NOP,
    K_LDI,
    K_ALU,
    K_HALT
  } kind_e;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS1_MSB = 8;
  localparam int unsigned RS1_LSB = 6;
  localparam int unsigned RS2_MSB = 5;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef struct packed {
    kind_e      kind;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm;
    logic [3:0] alu_op;
  } decode_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
  endfunction

endpackage

// File: rtl/instr_seq_decode.sv
// Combinational decode of a 16-bit instruction word into the decode record.
module instr_seq_decode
  import instr_seq_pkg::*;
(
  input  logic [15:0] instr_i,
  output decode_t     dec_o
);

  logic [3:0] opc;

  assign opc = instr_i[OPC_MSB:OPC_LSB];

  always_comb begin
    dec_o        = '0;
    dec_o.rd     = instr_i[RD_MSB:RD_LSB];
    dec_o.rs1    = instr_i[RS1_MSB:RS1_LSB];
    dec_o.rs2    = instr_i[RS2_MSB:RS2_LSB];
    dec_o.imm    = instr_i[IMM_MSB:IMM_LSB];
    dec_o.alu_op = opc;
    if (opc == OP_NOP) begin
      dec_o.kind = K_NOP;
    end else if (opc == OP_LDI) begin
      dec_o.kind = K_LDI;
    end else if (is_alu_op(opc)) begin
      dec_o.kind = K_ALU;
    end else begin
      dec_o.kind = K_HALT;
    end
  end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer feeding reg_file and the 8-bit ALU.
// Optional zero flag output enabled by defining INSTR_SEQ_ZFLAG_EN.
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [15:0]      instr_i,
  input  logic             resume_i,
  output logic [2:0]       rs1_addr_o,
  output logic [2:0]       rs2_addr_o,
  output logic [2:0]       rd_addr_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_wren_o,
  input  logic [7:0]       rs1_data_i,
  input  logic [7:0]       rs2_data_i,
  output logic [3:0]       alu_op_o,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  input  logic [7:0]       alu_result_i,
  output logic             busy_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
`ifdef INSTR_SEQ_ZFLAG_EN
  ,
  output logic             zero_o
`endif
);

  localparam logic [2:0] WaitInit = 3'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [15:0]      instr_q;
  logic [3:0]       alu_op_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic [7:0]       rd_data_q;
  logic [2:0]       wait_q;
  logic [CNT_W-1:0] retired_q;
  logic             accept;
  logic             retire;

  decode_t dec_in;
  decode_t dec_q;

  // Incoming word steers the IDLE dispatch; the latched word drives everything after.
  instr_seq_decode u_dec_in (
    .instr_i (instr_i),
    .dec_o   (dec_in)
  );

  instr_seq_decode u_dec_q (
    .instr_i (instr_q),
    .dec_o   (dec_q)
  );

  logic unused_dec;
  assign unused_dec = ^{dec_in.rd, dec_in.rs1, dec_in.rs2, dec_q.imm, dec_q.alu_op};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid_i) begin
          accept = 1'b1;
          unique case (dec_in.kind)
            K_NOP:  retire = 1'b1;
            K_LDI:  state_d = S_WB;
            K_ALU:  state_d = S_READ;
            K_HALT: begin
              state_d = S_HALT;
              retire  = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        if (wait_q == 3'd0) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_IDLE;
      end
      S_HALT: begin
        if (resume_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      rd_data_q <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instr_i;
        if (dec_in.kind == K_LDI) begin
          rd_data_q <= dec_in.imm;
        end
        if (dec_in.kind == K_ALU) begin
          alu_op_q <= dec_in.alu_op;
        end
      end
      if (state_q == S_READ) begin
        alu_a_q <= rs1_data_i;
        alu_b_q <= rs2_data_i;
        wait_q  <= WaitInit;
      end
      if (state_q == S_EXEC) begin
        if (wait_q == 3'd0) begin
          rd_data_q <= alu_result_i;
        end else begin
          wait_q <= wait_q - 3'd1;
        end
      end
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

`ifdef INSTR_SEQ_ZFLAG_EN
  logic zero_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
    end else if (state_q == S_WB && dec_q.kind == K_ALU) begin
      zero_q <= (rd_data_q == 8'h00);
    end
  end

  assign zero_o = zero_q;
`endif

  assign instr_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign halted_o      = (state_q == S_HALT);
  assign rd_wren_o     = (state_q == S_WB);
  assign rs1_addr_o    = dec_q.rs1;
  assign rs2_addr_o    = dec_q.rs2;
  assign rd_addr_o     = dec_q.rd;
  assign rd_data_o     = rd_data_q;
  assign alu_op_o      = alu_op_q;
  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign retired_o     = retired_q;

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Multi-cycle instruction sequencer, directly upstream of reg_file.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Drives reg_file read addresses and passes operands to the 8-bit ALU.
- Waits for the ALU result, then issues the single-cycle register write-back.
- Executes one instruction at a time, with no overlap and therefore no hazards.

Parameters:
- ALU_LAT, 1: cycles from ALU operand presentation to valid alu_result_i (legal range 1..7).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- instr_valid_i  in  1  instruction valid.
- instr_ready_o  out  1  sequencer can accept an instruction.
- instr_i  in  16  instruction word.
- resume_i  in  1  leave HALT.
- rs1_addr_o  out  3  to reg_file rs1_addr_i.
- rs2_addr_o  out  3  to reg_file rs2_addr_i.
- rd_addr_o  out  3  to reg_file rd_addr_i.
- rd_data_o  out  8  to reg_file rd_data_i.
- rd_wren_o  out  1  to reg_file rd_wren_i.
- rs1_data_i  in  8  from reg_file.
- rs2_data_i  in  8  from reg_file.
- alu_op_o  out  4  ALU operation code.
- alu_a_o  out  8  ALU operand A.
- alu_b_o  out  8  ALU operand B.
- alu_result_i  in  8  ALU result.
- busy_o  out  1  not in IDLE.
- halted_o  out  1  in HALT.
- retired_o  out  CNT_W  retired-instruction count.

Behaviour:
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only).
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI (rd <= imm).
  - 0x2..0xE ALU ops; alu_op_o = opcode unchanged.
  - 0xF HALT.
- Transfer occurs when instr_valid_i && instr_ready_o at a rising edge; the instruction is latched into an internal register.
- FSM states:
  - IDLE: instr_ready_o=1.
    - NOP: stays IDLE, retires that cycle.
    - LDI: goes to WB.
    - ALU op: goes to READ.
    - HALT: goes to HALT.
  - READ: rs1/rs2 addresses driven from the latched instruction; reg_file read is combinational; operands are captured into alu_a/alu_b registers at the end of the cycle; goes to EXEC.
  - EXEC: alu_a_o, alu_b_o and alu_op_o held stable; 3-bit wait counter runs ALU_LAT cycles; on the last cycle alu_result_i is captured; goes to WB.
  - WB: rd_wren_o=1 for exactly one cycle; rd_data_o = captured result or imm; retires; goes to IDLE.
  - HALT: instr_ready_o=0, halted_o=1, retires once on entry. resume_i=1 returns to IDLE next cycle.
- Latency, for an ALU op accepted at edge T:
  - READ in cycle T+1.
  - EXEC in cycles T+2 .. T+1+ALU_LAT.
  - WB in cycle T+2+ALU_LAT.
  - instr_ready_o high again from T+3+ALU_LAT.
- LDI accepted at T: WB in cycle T+1.
- rd == rs1 or rd == rs2 is legal: operands are read before write-back.
- retired_o increments once per retired instruction (NOP, LDI, ALU, HALT) and wraps modulo 2^CNT_W.
- Outputs outside their active state:
  - rd_wren_o=0.
  - rd_data_o, alu_a_o, alu_b_o hold their last values.
  - Address outputs follow the latched instruction fields.
- instr_valid_i while not ready is ignored; instr_i need not be held stable except at the accepting edge.
- resume_i outside HALT is ignored.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - rd_wren_o=0, busy_o=0, halted_o=0, instr_ready_o=1.
  - All data, address and op registers = 0; retired_o=0.
  - A reset during EXEC or WB aborts the instruction with no write.

Optional Feature:
- Macro: INSTR_SEQ_ZFLAG_EN.
- When defined:
  - Adds output zero_o (1 bit), a registered zero flag.
  - zero_o is updated in WB of ALU ops only: 1 if the written value == 0, else 0.
  - LDI, NOP and HALT leave zero_o unchanged.
  - Reset value 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package instr_seq_pkg:
  - opcode enum (OP_NOP, OP_LDI, OP_HALT, ALU range bounds).
  - state enum (S_IDLE, S_READ, S_EXEC, S_WB, S_HALT).
  - Instruction field bit-position constants.
  - Helper function is_alu_op.
- Sub-module instr_seq_decode: combinational decode of the latched instruction into a decode struct (kind, rd, rs1, rs2, imm, alu_op).
- FSM, counters and datapath registers stay in instr_seq.

Test Plan:
- Reset then LDI r3,0xA5 (instr 0x16A5) accepted at T:
  - rd_wren_o=1 at T+1 with rd_addr_o=3, rd_data_o=0xA5.
  - retired_o=1.
  - ready high at T+2.
- ALU op 0x2, rd=r1, rs1=r2 (0x10), rs2=r3 (0x05), ALU_LAT=2; model ALU result = a+b:
  - alu_a_o=0x10, alu_b_o=0x05 from T+2.
  - WB at T+4 writes 0x15 to r1.
  - instr_ready_o=0 from T+1 through T+4.
- Back-to-back NOPs with valid held high for 5 cycles:
  - ready stays 1, no writes, retired_o=5.
- HALT (0xF000):
  - halted_o=1, ready=0, and further valid is ignored for 10 cycles.
  - resume_i pulse -> IDLE next cycle; next LDI executes normally.
- rst_ni asserted mid-EXEC:
  - Immediately busy_o=0, rd_wren_o=0.
  - No write ever occurs for the aborted instruction; retired_o=0.
- With INSTR_SEQ_ZFLAG_EN, ALU op with result 0x00:
  - zero_o=1 after WB.
  - A following LDI 0x07 leaves zero_o=1.
  - A following ALU result 0x01 clears zero_o.
